fft_out_scaler: RTL
===================

Name: fft_out_scaler

Overview:
- Registered output-scaling stage directly downstream of the FFT/IFFT butterfly core.
- Divides each complex sample by 2^s with an arithmetic right shift; truncation or round-half-up is selectable.
- Tracks frame boundaries and generates sof/eof alongside the data.
- Uses a valid/ready handshake so the output consumer can apply backpressure. Typical use is the 1/N normalisation after an IFFT.

Parameters:
- DATA_W, 16: width of each real/imag component, two's complement.
- FRAME_LEN, 64: samples per frame (FFT size N), power of two, at least 2.
- SHIFT_W, 3: width of cfg_shift; maximum shift is 2^SHIFT_W-1, which must be less than DATA_W.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_shift  in  SHIFT_W  shift amount s; sampled only when an in_sof beat is accepted
- cfg_round  in  1  1 = round-half-up, 0 = truncate; sampled with cfg_shift
- in_valid  in  1  upstream sample valid
- in_ready  out  1  this stage can accept a sample
- in_sof  in  1  first sample of a frame; qualified by in_valid
- in_data  in  2*DATA_W  {real, imag}; real in upper half, matching the CPLX layout in fft_inc.h
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts the sample
- out_data  out  2*DATA_W  scaled {real, imag}
- out_sof  out  1  first sample of an output frame
- out_eof  out  1  last sample (index FRAME_LEN-1) of an output frame
- frame_err  out  1  one-cycle pulse on a framing violation

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_data=0, out_sof=0, out_eof=0, frame_err=0.
  - State goes to IDLE; sample counter=0; latched shift=0; latched round=0.
  - Reset mid-frame discards the frame and any held output.
- Handshake:
  - A transfer occurs on a cycle where valid=1 and ready=1.
  - in_ready = !out_valid || out_ready, which gives a single output register with full throughput.
  - out_data, out_sof and out_eof hold stable while out_valid=1 and out_ready=0.
- Latency: exactly 1 cycle from an accepted input beat to out_valid, when not stalled.
- State machine (IDLE, ACTIVE):
  - IDLE, accepted beat with in_sof=1: latch cfg_shift/cfg_round, load out register with out_sof=1, counter becomes 1, go to ACTIVE.
  - IDLE, accepted beat with in_sof=0: the beat is consumed and dropped (no output) and frame_err pulses.
  - ACTIVE, accepted beat with in_sof=0: emit the sample and increment the counter. When counter==FRAME_LEN-1 at acceptance, set out_eof=1, reset counter to 0 and go to IDLE.
  - ACTIVE, accepted beat with in_sof=1: frame_err pulses. The beat starts a new frame: relatch config, out_sof=1, counter=1, stay ACTIVE. The truncated previous frame gets no eof.
  - FRAME_LEN beats with sof on the first give exactly one out_sof and one out_eof.
- Arithmetic, per component x (signed DATA_W), shift s:
  - s=0: output = x, and cfg_round is ignored.
  - Truncate: output = x >>> s, arithmetic floor.
  - Round: output = (x + 2^(s-1)) >>> s, computed at DATA_W+1 bits then narrowed to DATA_W. This never overflows for s ≥ 1, so no saturation is needed.
  - Real and imaginary parts are processed independently and identically.
- Config changes mid-frame have no effect until the next accepted in_sof.
- frame_err is a single-cycle pulse on the acceptance cycle and is independent of out_ready.

Decomposition:
- fft_inc.h holds:
  - CPLX_WIDTH and REAL_MSB/REAL_LSB/IMGN_MSB/IMGN_LSB, reused unchanged.
  - New define FFT_LEN (default for FRAME_LEN).
  - New localparam-style defines for the state encoding (ST_IDLE, ST_ACTIVE).
- Sub-module fft_cplx_shift_rnd: combinational per-sample divider (idata, shift, round → odata). It is instantiated once, and all stage logic is in fft_out_scaler.

Test Plan:
- Truncate vs round, DATA_W=16, s=7. Real=192, imag=-192:
  - cfg_round=0 → out real=1, imag=-2.
  - cfg_round=1 → out real=2, imag=-1.
- Full frame, FRAME_LEN=64, continuous valid, out_ready=1, ramp input:
  - out_valid 1 cycle after each accept.
  - out_sof on sample 0 only, out_eof on sample 63 only.
  - 64 outputs, zero frame_err.
- Backpressure: hold out_ready=0 for 5 cycles mid-frame:
  - in_ready=0 and out_data stable throughout.
  - After release no sample is lost or duplicated, and eof is still on the 64th.
- Config isolation: start frame with s=6, change cfg_shift to 0 at sample 10:
  - all 64 samples are scaled by 2^-6.
  - The next frame with sof uses s=0.
- Framing errors:
  - Beat with in_sof=0 in IDLE → dropped, frame_err=1 for one cycle.
  - in_sof at sample 20 → frame_err pulse, out_sof reasserted, no eof for the aborted frame.
- Async reset: assert rst_n=0 mid-frame between clock edges:
  - out_valid drops immediately.
  - After release, the first accepted sof beat produces a normal frame.

Source files
------------

// File: rtl/fft_out_scaler_pkg.sv
// Shared definitions for the FFT output scaling stage: default frame size,
// complex-sample layout helpers and the frame-tracking state encoding.
package fft_out_scaler_pkg;

    // Default FFT size N; used as the default frame length.
    localparam int FFT_LEN = 64;

    // Complex samples are packed {real, imag} with the real part in the upper half.
    function automatic int real_msb(input int data_w);
        return 2 * data_w - 1;
    endfunction

    function automatic int real_lsb(input int data_w);
        return data_w;
    endfunction

    // Frame tracking: IDLE waits for a start-of-frame beat, ACTIVE counts samples.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

endpackage

// File: rtl/fft_cplx_shift_rnd.sv
// Combinational per-sample divider: scales both components of a complex sample
// by 2^-shift using an arithmetic shift, either truncating or rounding half-up.
module fft_cplx_shift_rnd
    import fft_out_scaler_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int SHIFT_W = 3
) (
    input  logic [2*DATA_W-1:0] idata_i,
    input  logic [SHIFT_W-1:0]  shift_i,
    input  logic                round_i,
    output logic [2*DATA_W-1:0] odata_o
);

    localparam int RE_MSB = real_msb(DATA_W);
    localparam int RE_LSB = real_lsb(DATA_W);
    localparam logic signed [DATA_W:0] ONE = {{DATA_W{1'b0}}, 1'b1};

    // One extra bit of headroom keeps x + 2^(s-1) exact; the shifted result
    // always fits back into DATA_W bits for s >= 1, and s = 0 passes x through.
    function automatic logic [DATA_W-1:0] scale_one(
        input logic [DATA_W-1:0]  x,
        input logic [SHIFT_W-1:0] s,
        input logic               rnd
    );
        logic signed [DATA_W:0] ext;
        logic signed [DATA_W:0] inc;
        logic signed [DATA_W:0] sum;
        ext = {x[DATA_W-1], x};
        inc = '0;
        if (rnd && (s != '0)) begin
            inc = ONE <<< (s - SHIFT_W'(1));
        end
        sum = ext + inc;
        sum = sum >>> s;
        return sum[DATA_W-1:0];
    endfunction

    // Real and imaginary halves are scaled independently with the same settings.
    always_comb begin
        odata_o = '0;
        odata_o[RE_MSB:RE_LSB]   = scale_one(idata_i[RE_MSB:RE_LSB], shift_i, round_i);
        odata_o[DATA_W-1:0]      = scale_one(idata_i[DATA_W-1:0], shift_i, round_i);
    end

endmodule

// File: rtl/fft_out_scaler.sv
// Registered output-scaling stage behind the FFT/IFFT core. Divides each sample
// by 2^s, tracks frame boundaries to produce sof/eof, and flags framing errors.
// Handshake: a beat moves on any cycle where valid and ready are both high;
// in_ready is high whenever the single output register is empty or being
// drained, and held output fields stay stable while out_valid && !out_ready.
module fft_out_scaler
    import fft_out_scaler_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = FFT_LEN,
    parameter int SHIFT_W   = 3
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [SHIFT_W-1:0]  cfg_shift_i,
    input  logic                cfg_round_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic                in_sof_i,
    input  logic [2*DATA_W-1:0] in_data_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [2*DATA_W-1:0] out_data_o,
    output logic                out_sof_o,
    output logic                out_eof_o,
    output logic                frame_err_o
);

    localparam int CNT_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [SHIFT_W-1:0]  shift_q;
    logic                round_q;
    logic                out_valid_q;
    logic                out_sof_q;
    logic                out_eof_q;
    logic                frame_err_q;
    logic [2*DATA_W-1:0] out_data_q;
    logic [2*DATA_W-1:0] out_data_d;

    logic                accept;
    logic                start_beat;
    logic                cont_beat;
    logic                err_beat;
    logic                last_beat;
    logic [SHIFT_W-1:0]  shift_sel;
    logic                round_sel;

    assign in_ready_o = !out_valid_q || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;
    assign start_beat = accept && in_sof_i;
    assign cont_beat  = accept && !in_sof_i && (state_q == ST_ACTIVE);
    assign last_beat  = cont_beat && (cnt_q == LAST_IDX);
    // A sof while ACTIVE aborts the frame; a non-sof beat while IDLE is orphaned.
    assign err_beat   = accept && (in_sof_i ? (state_q == ST_ACTIVE) : (state_q == ST_IDLE));

    // The sof beat itself is scaled with the configuration being latched with it.
    assign shift_sel = start_beat ? cfg_shift_i : shift_q;
    assign round_sel = start_beat ? cfg_round_i : round_q;

    fft_cplx_shift_rnd #(
        .DATA_W (DATA_W),
        .SHIFT_W(SHIFT_W)
    ) u_div (
        .idata_i(in_data_i),
        .shift_i(shift_sel),
        .round_i(round_sel),
        .odata_o(out_data_d)
    );

    // Frame FSM, config latch and output register, all updated on accepted beats.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            round_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            out_data_q  <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= err_beat;
            if (start_beat) begin
                state_q <= ST_ACTIVE;
                cnt_q   <= CNT_W'(1);
                shift_q <= cfg_shift_i;
                round_q <= cfg_round_i;
            end else if (cont_beat) begin
                if (last_beat) begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
            if (start_beat || cont_beat) begin
                out_valid_q <= 1'b1;
                out_data_q  <= out_data_d;
                out_sof_q   <= start_beat;
                out_eof_q   <= last_beat;
            end else if (out_ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_sof_o   = out_sof_q;
    assign out_eof_o   = out_eof_q;
    assign frame_err_o = frame_err_q;

endmodule
